fetch_buffer_stage: RTL
=======================

Name: fetch_buffer_stage

Overview:
- Instruction fetch stage with a small prefetch queue, directly upstream of decode_reg_r.
- Owns the fetch PC and drives a synchronous instruction-memory port with 1-cycle read latency.
- Buffers returned words so decode sees stable, valid-tagged {inst, pc} pairs under stall.
- Handles branch redirect from write-back and flush from decode without losing or duplicating instructions on the correct path.

Parameters:
- ADDR_W, 8, word-address width of instruction memory (IMEM = 2^ADDR_W words).
- Q_DEPTH, 2, prefetch queue entries (power of two, >=2).
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- branch_i  in  1  redirect request from write-back.
- pc_wb_i  in  32  redirect target, sampled when branch_i=1.
- flush_i  in  1  discard all buffered/in-flight instructions.
- stall_i  in  1  decode cannot accept this cycle.
- imem_addr_o  out  ADDR_W  word address to instruction memory = fpc[ADDR_W+1:2].
- imem_data_i  in  32  read data, valid the cycle after the address is issued.
- valid_o  out  1  inst_o/pc_o hold a live instruction.
- inst_o  out  32  instruction at queue head.
- pc_o  out  32  byte PC of inst_o.
- fetch_pc_o  out  32  current fetch PC (debug port).

Behaviour:
- State:
  - fpc (32b).
  - req_v/req_pc: tag for the in-flight read.
  - Circular queue of Q_DEPTH {inst, pc}, with rd_ptr, wr_ptr and count (log2(Q_DEPTH)+1 bits).
- Reset (async, reset_i=0):
  - fpc=RESET_PC, req_v=0, count=0, pointers=0.
  - valid_o=0, inst_o=0, pc_o=0, imem_addr_o=RESET_PC[ADDR_W+1:2].
  - Applies immediately mid-operation; in-flight data is ignored.
- Outputs: valid_o = (count!=0). inst_o/pc_o = head entry when valid, else 0. Registered-queue driven; no combinational path from imem_data_i.
- pop = valid_o & ~stall_i. push = req_v & ~branch_i & ~flush_i (captures imem_data_i with req_pc).
- issue = ~branch_i & ~flush_i & ((count + req_v - pop) < Q_DEPTH).
  - Issue: address presented, req_v<=1, req_pc<=fpc, fpc<=fpc+4 (mod 2^32).
  - No issue: req_v<=0, fpc held.
- Latency: issue in cycle N, queue write at end of N+1, valid_o high in N+2. Steady state with stall_i=0 sustains 1 instruction/cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo Q_DEPTH.
- Full: issue suppressed, so a push never occurs with count=Q_DEPTH.
- Stall: head entry and valid_o held stable. Fetch continues until the queue plus in-flight reaches Q_DEPTH.
- branch_i (priority over flush_i):
  - count<=0, pointers<=0, req_v<=0; in-flight data discarded.
  - fpc<=pc_wb_i & ~32'h3; no issue this cycle.
  - First new address issued next cycle; valid_o for the target 3 cycles after the branch_i cycle.
- flush_i without branch_i:
  - Queue emptied, in-flight discarded, issue suppressed while high, fpc frozen.
  - Instructions between the flushed point and fpc are dropped by design; decode always pairs flush with a subsequent branch_i.
- branch_i and flush_i together: branch behaviour.
- Unaligned pc_wb_i is forced word-aligned. PC wrap 32'hFFFF_FFFC -> 0. imem_addr_o wraps modulo 2^ADDR_W.
- Nothing enters the queue except via push; no X propagation onto valid_o.

Test Plan:
- Reset release, IMEM[k]=32'hE000_0000+k, stall_i=0 -> valid_o first high 2 cycles after reset deasserts; pc_o=0,4,8,... and inst_o=E0000000,E0000001,... on consecutive cycles, no gaps.
- stall_i high 5 cycles while streaming -> inst_o/pc_o frozen (pc_o=8); imem_addr_o stops advancing after the queue plus in-flight equals 2. On release, pc_o=8,C,10 in order with no duplicate or skip.
- branch_i=1, pc_wb_i=32'h0000_0042 mid-stream -> valid_o=0 next cycle; 3 cycles later pc_o=32'h40, inst_o=IMEM[16], then 44, 48. No pre-branch instruction appears.
- flush_i and branch_i in the same cycle (target 32'h80), plus stall_i=1 -> branch wins; queue cleared; pc_o=80 held under stall until stall_i drops.
- fpc near top: branch to 32'h0000_03FC with ADDR_W=8 -> imem_addr_o=8'hFF, then 8'h00; pc_o=3FC then 400.
- reset_i asserted asynchronously mid-cycle with count=2 -> valid_o drops to 0 without a clock edge; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_buffer_stage.sv
// Instruction fetch stage with a small circular prefetch queue.
// Owns the fetch PC, drives a 1-cycle-latency synchronous IMEM port and hands
// decode stable {inst, pc} pairs. Branch redirect and flush discard everything
// buffered or in flight; branch wins when both arrive together.
module fetch_buffer_stage #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned Q_DEPTH  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              branch_i,
  input  logic [31:0]       pc_wb_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_data_i,
  output logic              valid_o,
  output logic [31:0]       inst_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       fetch_pc_o
);
  localparam int unsigned PTR_W = $clog2(Q_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  // Depth at the occupancy-sum width so the issue compare is width-matched.
  localparam logic [CNT_W:0] DEPTH_C = Q_DEPTH[CNT_W:0];

  logic [31:0]              r_fpc;
  logic                     r_req_v;
  logic [31:0]              r_req_pc;
  logic [Q_DEPTH-1:0][31:0] r_q_inst;
  logic [Q_DEPTH-1:0][31:0] r_q_pc;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [CNT_W-1:0]         r_count;

  logic                     w_pop;
  logic                     w_push;
  logic                     w_issue;
  logic                     w_kill;
  logic [CNT_W:0]           w_occ;

  assign w_kill  = branch_i | flush_i;
  assign valid_o = (r_count != '0);
  assign w_pop   = valid_o & ~stall_i;
  // The returning word belongs to the tagged request unless it is being killed.
  assign w_push  = r_req_v & ~w_kill;

  // Occupancy next cycle if we issue now: buffered + in flight - leaving.
  // Never underflows: w_pop implies r_count >= 1.
  assign w_occ   = {1'b0, r_count}
                 + {{CNT_W{1'b0}}, r_req_v}
                 - {{CNT_W{1'b0}}, w_pop};
  assign w_issue = ~w_kill & (w_occ < DEPTH_C);

  // Outputs come only from registered state; idle head reads as zero.
  assign inst_o      = valid_o ? r_q_inst[r_rd_ptr] : 32'h0;
  assign pc_o        = valid_o ? r_q_pc[r_rd_ptr]   : 32'h0;
  assign imem_addr_o = r_fpc[ADDR_W+1:2];
  assign fetch_pc_o  = r_fpc;

  // Fetch PC and in-flight request tag; branch redirects, flush freezes.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_fpc    <= RESET_PC;
      r_req_v  <= 1'b0;
      r_req_pc <= 32'h0;
    end else if (branch_i) begin
      r_fpc   <= pc_wb_i & ~32'h3;
      r_req_v <= 1'b0;
    end else if (w_issue) begin
      r_req_v  <= 1'b1;
      r_req_pc <= r_fpc;
      r_fpc    <= r_fpc + 32'd4;
    end else begin
      r_req_v <= 1'b0;
    end
  end

  // Queue bookkeeping: pointers wrap at the power-of-two depth.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_kill) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents are only observable through valid entries.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_q_inst[r_wr_ptr] <= imem_data_i;
      r_q_pc[r_wr_ptr]   <= r_req_pc;
    end
  end

endmodule
